// File: rtl/neck_pkg.sv
// neck_pkg: shared definitions for the neck detector family.
//   - neck_state_e : FSM state encoding (idle / confirm / neck / hold-off)
//   - DEF_*        : default derivative thresholds and timing limits
//   - cnt_width()  : bits needed to hold a counter limit, i.e. $clog2(max+1), min 1
package neck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_NECK,
        ST_HOLDOFF
    } neck_state_e;

    localparam int DEF_W         = 13;
    localparam int DEF_D1_MIN    = 12;
    localparam int DEF_D2_START  = 22;
    localparam int DEF_D2_END    = -19;
    localparam int DEF_D3_LO     = -25;
    localparam int DEF_D3_HI     = 29;
    localparam int DEF_CONFIRM_N = 2;
    localparam int DEF_OFF_MIN   = 4;
    localparam int DEF_OFF_MAX   = 200;
    localparam int DEF_HOLDOFF   = 8;
    localparam int DEF_CNT_W     = 16;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/neck_qualifier.sv
// neck_qualifier: purely combinational neck-start / neck-end qualification.
//   en_judge   in  sample valid this cycle
//   d1/d2/d3   in  signed first/second/third-order current derivatives
//   neck_start out valid sample inside the d1/d3 window with d2 above start threshold
//   neck_end   out valid sample inside the d1/d3 window with d2 below end threshold
module neck_qualifier
    import neck_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int D1_MIN   = DEF_D1_MIN,
    parameter int D2_START = DEF_D2_START,
    parameter int D2_END   = DEF_D2_END,
    parameter int D3_LO    = DEF_D3_LO,
    parameter int D3_HI    = DEF_D3_HI
) (
    input  logic                en_judge,
    input  logic signed [W-1:0] d1,
    input  logic signed [W-1:0] d2,
    input  logic signed [W-1:0] d3,
    output logic                neck_start,
    output logic                neck_end
);

    // Thresholds narrowed to the sample width so every compare is W-bit signed.
    localparam logic signed [W-1:0] D1_MIN_W   = W'(D1_MIN);
    localparam logic signed [W-1:0] D2_START_W = W'(D2_START);
    localparam logic signed [W-1:0] D2_END_W   = W'(D2_END);
    localparam logic signed [W-1:0] D3_LO_W    = W'(D3_LO);
    localparam logic signed [W-1:0] D3_HI_W    = W'(D3_HI);

    logic win;

    always_comb begin
        win        = (d1 > D1_MIN_W) && (d3 > D3_LO_W) && (d3 < D3_HI_W);
        neck_start = en_judge && win && (d2 > D2_START_W);
        neck_end   = en_judge && win && (d2 < D2_END_W);
    end

endmodule

// File: rtl/neck_detect_fsm.sv
// neck_detect_fsm: debounced neck detector driving the welder power switch.
//   clk, rst_n     in  clock, synchronous active-low reset
//   en_judge       in  d1/d2/d3 valid this cycle
//   d1/d2/d3       in  signed current derivatives
//   power_switch   out 1 = supply on (registered)
//   neck_active    out high while in NECK (registered)
//   timeout_pulse  out one-cycle pulse on the first cycle after an OFF_MAX expiry
//   neck_count     out wrapping count of NECK entries
module neck_detect_fsm
    import neck_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int D1_MIN    = DEF_D1_MIN,
    parameter int D2_START  = DEF_D2_START,
    parameter int D2_END    = DEF_D2_END,
    parameter int D3_LO     = DEF_D3_LO,
    parameter int D3_HI     = DEF_D3_HI,
    parameter int CONFIRM_N = DEF_CONFIRM_N,
    parameter int OFF_MIN   = DEF_OFF_MIN,
    parameter int OFF_MAX   = DEF_OFF_MAX,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_judge,
    input  logic signed [W-1:0] d1,
    input  logic signed [W-1:0] d2,
    input  logic signed [W-1:0] d3,
    output logic                power_switch,
    output logic                neck_active,
    output logic                timeout_pulse,
    output logic [CNT_W-1:0]    neck_count
);

    localparam int unsigned CONF_W = cnt_width(CONFIRM_N);
    localparam int unsigned OFF_W  = cnt_width(OFF_MAX);
    localparam int unsigned HOLD_W = cnt_width(HOLDOFF);

    // With no hold-off window a finished neck drops straight back to IDLE.
    localparam neck_state_e POST_NECK = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

    neck_state_e         state_q, state_d;
    logic [CONF_W-1:0]   conf_cnt_q, conf_cnt_d;
    logic [OFF_W-1:0]    off_cnt_q, off_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    neck_count_q, neck_count_d;
    logic                power_switch_q, power_switch_d;
    logic                neck_active_q, neck_active_d;
    logic                timeout_pulse_q, timeout_pulse_d;
    logic                q_start, q_end;
    logic                expire;

    neck_qualifier #(
        .W        (W),
        .D1_MIN   (D1_MIN),
        .D2_START (D2_START),
        .D2_END   (D2_END),
        .D3_LO    (D3_LO),
        .D3_HI    (D3_HI)
    ) u_qual (
        .en_judge   (en_judge),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .neck_start (q_start),
        .neck_end   (q_end)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            conf_cnt_q      <= '0;
            off_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            neck_count_q    <= '0;
            power_switch_q  <= 1'b1;
            neck_active_q   <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            conf_cnt_q      <= conf_cnt_d;
            off_cnt_q       <= off_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            neck_count_q    <= neck_count_d;
            power_switch_q  <= power_switch_d;
            neck_active_q   <= neck_active_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    // Next-state and counter logic. off_cnt/hold_cnt are held at zero outside
    // their own states, so entering NECK or HOLDOFF always starts from zero.
    always_comb begin
        state_d    = state_q;
        conf_cnt_d = conf_cnt_q;
        off_cnt_d  = '0;
        hold_cnt_d = '0;
        expire     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                conf_cnt_d = '0;
                if (q_start) begin
                    if (CONFIRM_N <= 1) begin
                        state_d = ST_NECK;
                    end else begin
                        state_d    = ST_CONFIRM;
                        conf_cnt_d = CONF_W'(1);
                    end
                end
            end
            ST_CONFIRM: begin
                if (en_judge) begin
                    if (q_start) begin
                        if (conf_cnt_q >= CONF_W'(CONFIRM_N - 1)) begin
                            state_d    = ST_NECK;
                            conf_cnt_d = '0;
                        end else begin
                            conf_cnt_d = conf_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d    = ST_IDLE;
                        conf_cnt_d = '0;
                    end
                end
            end
            ST_NECK: begin
                off_cnt_d = (off_cnt_q == OFF_W'(OFF_MAX)) ? off_cnt_q : off_cnt_q + 1'b1;
                // An accepted end takes priority over expiry in the same cycle.
                if (q_end && (off_cnt_q >= OFF_W'(OFF_MIN))) begin
                    state_d = POST_NECK;
                end else if (off_cnt_q >= OFF_W'(OFF_MAX - 1)) begin
                    state_d = POST_NECK;
                    expire  = 1'b1;
                end
                if (state_d != ST_NECK) begin
                    off_cnt_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q >= HOLD_W'(HOLDOFF - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                conf_cnt_d = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they appear one clock after
    // the qualifying sample, straight out of flops.
    always_comb begin
        power_switch_d  = (state_d != ST_NECK);
        neck_active_d   = (state_d == ST_NECK);
        timeout_pulse_d = expire;
        neck_count_d    = neck_count_q;
        if ((state_d == ST_NECK) && (state_q != ST_NECK)) begin
            neck_count_d = neck_count_q + CNT_W'(1);
        end
    end

    assign power_switch  = power_switch_q;
    assign neck_active   = neck_active_q;
    assign timeout_pulse = timeout_pulse_q;
    assign neck_count    = neck_count_q;

endmodule

// File: tb/tb_neck_detect_fsm.sv
// tb_neck_detect_fsm: directed bench for neck_detect_fsm with a timestamp-based
// reference model checked after every clock, plus literal expectations.
module tb_neck_detect_fsm;

    localparam int TW        = 13;
    localparam int T_D1_MIN  = 12;
    localparam int T_D2_ST   = 22;
    localparam int T_D2_END  = -19;
    localparam int T_D3_LO   = -25;
    localparam int T_D3_HI   = 29;
    localparam int T_CONF_N  = 2;
    localparam int T_OFF_MIN = 4;
    localparam int T_OFF_MAX = 200;
    localparam int T_HOLD    = 8;
    localparam int T_CNT_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en_judge;
    logic signed [TW-1:0] d1, d2, d3;
    logic                 power_switch;
    logic                 neck_active;
    logic                 timeout_pulse;
    logic [T_CNT_W-1:0]   neck_count;

    always #5 clk = ~clk;

    neck_detect_fsm #(
        .W         (TW),
        .D1_MIN    (T_D1_MIN),
        .D2_START  (T_D2_ST),
        .D2_END    (T_D2_END),
        .D3_LO     (T_D3_LO),
        .D3_HI     (T_D3_HI),
        .CONFIRM_N (T_CONF_N),
        .OFF_MIN   (T_OFF_MIN),
        .OFF_MAX   (T_OFF_MAX),
        .HOLDOFF   (T_HOLD),
        .CNT_W     (T_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_judge      (en_judge),
        .d1            (d1),
        .d2            (d2),
        .d3            (d3),
        .power_switch  (power_switch),
        .neck_active   (neck_active),
        .timeout_pulse (timeout_pulse),
        .neck_count    (neck_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: edge index, start streak, NECK entry edge, last ignored edge.
    int m_edge      = 0;
    int m_streak    = 0;
    int m_entry     = 0;
    int m_hold_last = -1;
    int m_count     = 0;
    bit m_neck      = 1'b0;
    bit m_pulse     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  a, b, c, elapsed;
        bit  win, s, e;
        m_edge++;
        m_pulse = 1'b0;
        if (!rst_n) begin
            m_neck      = 1'b0;
            m_streak    = 0;
            m_count     = 0;
            m_hold_last = m_edge;
        end else begin
            a   = int'(d1);
            b   = int'(d2);
            c   = int'(d3);
            win = (a > T_D1_MIN) && (c > T_D3_LO) && (c < T_D3_HI);
            s   = en_judge && win && (b > T_D2_ST);
            e   = en_judge && win && (b < T_D2_END);
            if (m_neck) begin
                elapsed = m_edge - m_entry - 1;
                if (e && elapsed >= T_OFF_MIN) begin
                    m_neck      = 1'b0;
                    m_hold_last = m_edge + T_HOLD;
                end else if (elapsed == T_OFF_MAX - 1) begin
                    m_neck      = 1'b0;
                    m_pulse     = 1'b1;
                    m_hold_last = m_edge + T_HOLD;
                end
            end else if (m_edge > m_hold_last) begin
                if (en_judge) m_streak = s ? m_streak + 1 : 0;
                if (m_streak == T_CONF_N) begin
                    m_neck   = 1'b1;
                    m_entry  = m_edge;
                    m_count  = (m_count + 1) % (1 << T_CNT_W);
                    m_streak = 0;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, update the model, check at negedge.
    task automatic step(input bit r, input bit en, input int a, input int b, input int c);
        rst_n    = r;
        en_judge = en;
        d1       = TW'(a);
        d2       = TW'(b);
        d3       = TW'(c);
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("power_switch",  32'(power_switch),  32'(!m_neck));
        chk("neck_active",   32'(neck_active),   32'(m_neck));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        chk("neck_count",    32'(neck_count),    32'(m_count));
    endtask

    task automatic start2();
        step(1, 1, 13, 23, 0);
        step(1, 1, 13, 23, 0);
    endtask

    task automatic neutral(input int k);
        for (int i = 0; i < k; i++) step(1, 1, 0, 0, 0);
    endtask

    // Applies one sample repeatedly until power returns; result is clocks taken.
    task automatic run_until_on(input int a, input int b, input int c, input int max, output int cnt);
        cnt = 0;
        do begin
            step(1, 1, a, b, c);
            cnt++;
        end while (power_switch !== 1'b1 && cnt < max);
        if (power_switch !== 1'b1) chk("bound_power_on", 32'(power_switch), 32'd1);
    endtask

    initial begin
        int cnt;
        int bv [4][3];
        bv = '{'{12, 23, 0}, '{13, 22, 0}, '{13, 23, 29}, '{13, 23, -25}};

        // Reset with a qualifying-looking sample held on the inputs.
        repeat (3) step(0, 1, 50, 30, 0);
        chk("lit_reset_power", 32'(power_switch), 32'd1);
        chk("lit_reset_count", 32'(neck_count), 32'd0);
        chk("lit_reset_neck",  32'(neck_active), 32'd0);
        step(1, 1, 0, 0, 0);

        // Two starts: power drops after the second.
        step(1, 1, 13, 23, 0);
        chk("lit_confirm_on", 32'(power_switch), 32'd1);
        step(1, 1, 13, 23, 0);
        chk("lit_neck_off",   32'(power_switch), 32'd0);
        chk("lit_neck_count", 32'(neck_count), 32'd1);

        // Continuous ends: off for OFF_MIN+1 = 5 clocks.
        run_until_on(13, -20, 0, 300, cnt);
        chk("lit_min_off", 32'(cnt), 32'd5);
        chk("lit_min_off_pulse", 32'(timeout_pulse), 32'd0);

        // Starts during the 8 hold-off clocks are ignored.
        repeat (8) step(1, 1, 13, 23, 0);
        chk("lit_holdoff_on", 32'(power_switch), 32'd1);
        step(1, 1, 13, 23, 0);
        chk("lit_after_hold_1", 32'(power_switch), 32'd1);
        step(1, 1, 13, 23, 0);
        chk("lit_after_hold_2", 32'(power_switch), 32'd0);
        run_until_on(13, -20, 0, 300, cnt);
        neutral(8);

        // Debounce broken by a valid non-start sample.
        step(1, 1, 13, 23, 0);
        step(1, 1, 0, 0, 0);
        chk("lit_debounce_break", 32'(power_switch), 32'd1);
        // en_judge gap does not break it.
        step(1, 1, 13, 23, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 13, 23, 0);
        chk("lit_gap_neck", 32'(power_switch), 32'd0);
        chk("lit_gap_count", 32'(neck_count), 32'd3);
        run_until_on(13, -20, 0, 300, cnt);
        neutral(8);

        // Threshold boundaries: none of these qualify.
        foreach (bv[i]) begin
            step(1, 1, bv[i][0], bv[i][1], bv[i][2]);
            step(1, 1, bv[i][0], bv[i][1], bv[i][2]);
            chk("lit_boundary_nostart", 32'(power_switch), 32'd1);
        end
        step(1, 1, 13, 23, 28);
        step(1, 1, 13, 23, 28);
        chk("lit_boundary_start", 32'(power_switch), 32'd0);
        // d2 = -19 is not an end.
        repeat (10) step(1, 1, 13, -19, 0);
        chk("lit_end_boundary", 32'(power_switch), 32'd0);
        run_until_on(13, -20, 0, 300, cnt);
        chk("lit_late_end", 32'(cnt), 32'd1);
        neutral(8);

        // Timeout: off exactly OFF_MAX clocks, pulse on the return cycle only.
        start2();
        run_until_on(0, 0, 0, 300, cnt);
        chk("lit_timeout_len", 32'(cnt), 32'd200);
        chk("lit_timeout_pulse", 32'(timeout_pulse), 32'd1);
        step(1, 1, 0, 0, 0);
        chk("lit_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
        neutral(7);

        // End at off_cnt = 199 wins over expiry.
        start2();
        neutral(199);
        chk("lit_end199_pre", 32'(power_switch), 32'd0);
        step(1, 1, 13, -20, 0);
        chk("lit_end199_on", 32'(power_switch), 32'd1);
        chk("lit_end199_nopulse", 32'(timeout_pulse), 32'd0);
        neutral(8);
        chk("lit_count6", 32'(neck_count), 32'd6);

        // Ten more necks make 16 entries: 4-bit counter wraps to 0.
        repeat (10) begin
            start2();
            run_until_on(13, -20, 0, 300, cnt);
            neutral(8);
        end
        chk("lit_count_wrap", 32'(neck_count), 32'd0);

        // Reset mid-NECK restores power on the next edge.
        start2();
        neutral(3);
        step(0, 1, 0, 0, 0);
        chk("lit_reset_mid_neck", 32'(power_switch), 32'd1);
        step(1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neck_detect_fsm.md
# neck_detect_fsm

Parametrised, clocked successor to the combinational neck judge in the short-circuit welding control path. It qualifies neck-start and neck-end events from the first/second/third-order current-derivative streams against parameter thresholds, and debounces the start over consecutive samples. It holds the welder supply off for a bounded window (minimum and maximum off-time), then enforces a hold-off before re-arming. It drives the power switch directly and exposes status and event counting for the supervisor.

## Interface
Parameters:
- W, 13, signed width of derivative inputs
- D1_MIN, 12, first-order lower bound (strict >)
- D2_START, 22, second-order start threshold (strict >)
- D2_END, -19, second-order end threshold (strict <)
- D3_LO, -25, third-order window low bound (strict >)
- D3_HI, 29, third-order window high bound (strict <)
- CONFIRM_N, 2, consecutive qualifying start samples required (≥1)
- OFF_MIN, 4, clocks in NECK before an end is accepted (≥0, < OFF_MAX)
- OFF_MAX, 200, maximum clocks power may stay off
- HOLDOFF, 8, clocks after a neck in which starts are ignored (≥0)
- CNT_W, 16, neck event counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- en_judge  in  1  sample valid for d1/d2/d3 this cycle
- d1  in  W  signed first-order derivative
- d2  in  W  signed second-order derivative
- d3  in  W  signed third-order derivative
- power_switch  out  1  1 = supply on, 0 = supply off (registered)
- neck_active  out  1  high while in NECK (registered)
- timeout_pulse  out  1  one-cycle pulse on OFF_MAX expiry
- neck_count  out  CNT_W  number of NECK entries, wraps

## Operation
- Common qualifier (signed compares): win = d1>D1_MIN && d3>D3_LO && d3<D3_HI. start = en_judge && win && d2>D2_START. end = en_judge && win && d2<D2_END. A valid sample is any cycle with en_judge=1.
- States: IDLE, CONFIRM, NECK, HOLDOFF.
- IDLE (power on): start with CONFIRM_N=1 → NECK; start with CONFIRM_N>1 → CONFIRM, conf_cnt=1.
- CONFIRM (power on): a start increments conf_cnt and goes to NECK when conf_cnt reaches CONFIRM_N. A valid non-start sample → IDLE. en_judge=0 holds state and count.
- NECK (power off): off_cnt clears on entry and increments every clock, whatever en_judge is. An end with off_cnt ≥ OFF_MIN → HOLDOFF. An end with off_cnt < OFF_MIN is ignored. No accepted end by off_cnt = OFF_MAX-1 → HOLDOFF with timeout_pulse. An accepted end and expiry in the same cycle: the end wins and there is no pulse. Start samples are ignored.
- HOLDOFF (power on): counts HOLDOFF clocks, then → IDLE. HOLDOFF=0 → IDLE directly on the next clock. All samples are ignored.
- neck_count increments by 1 on each transition into NECK and wraps at 2^CNT_W.
- Counter widths: $clog2(max+1) of their respective limits. off_cnt saturates and never wraps.

## Timing
- Reset values: power_switch=1, neck_active=0, timeout_pulse=0, neck_count=0, state=IDLE, all internal counters 0.
- Latency is one clock. A qualifying sample at edge k changes power_switch/neck_active at edge k+1.
- Power off duration: ≥ OFF_MIN+1 clocks; exactly OFF_MAX clocks on timeout.
- timeout_pulse is high for exactly the first HOLDOFF cycle, i.e. it coincides with power_switch returning to 1.
- Reset asserted mid-NECK restores power_switch=1 at the next edge. neck_count is cleared.
- The outputs never glitch. All outputs come from flops.

## Structure
- Package neck_pkg: state enum (IDLE, CONFIRM, NECK, HOLDOFF), default threshold constants, and a log2 helper for counter widths.
- Sub-module neck_qualifier: registers nothing and produces start/end from d1/d2/d3/en_judge plus the threshold parameters. It is reused by future channel-replicated variants.
- Top level: FSM, conf_cnt, off_cnt, hold_cnt, neck_count, output registers.

## Test plan
- Reset/idle: rst_n=0 for 3 clocks with d1=50, d2=30, d3=0, en_judge=1 → power_switch=1, neck_count=0. After release, a start at cycle t gives power_switch=0 at t+2 (CONFIRM_N=2).
- Debounce break: one start sample (d1=13, d2=23, d3=0), then a valid sample with d2=0 → stays on, state IDLE. Same with an en_judge=0 gap between two starts → enters NECK.
- Min off-time: enter NECK, apply end (d1=13, d2=-20, d3=0) every cycle → power_switch low exactly 5 clocks (OFF_MIN=4), then 8 clocks of HOLDOFF in which starts are ignored.
- Boundary thresholds: d1=12 or d2=22 or d3=29 or d3=-25 → no start. d1=13, d2=23, d3=28 → start.
- Timeout: enter NECK, never supply an end → power low 200 clocks, timeout_pulse high 1 clock on return. Also an end at off_cnt=199 → no pulse.
- Counter wrap: CNT_W=4, 16 complete necks → neck_count returns to 0.
